debounce_toggle_pulse: RTL

//  Qualifies a raw, asynchronous push-button input and emits a single-cycle pulse per accepted press.

---
 rtl/debounce_defs.sv | 13 +
 rtl/sync_2ff.sv | 21 ++
 rtl/debounce_toggle_pulse.sv | 114 +++++++++++
 3 files changed

// File: rtl/debounce_defs.sv
// Shared definitions for the button front-ends: FSM state encodings and default qualification length.
package debounce_defs;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE_LOW  = 2'd0;
    localparam state_t WAIT_HIGH = 2'd1;
    localparam state_t IDLE_HIGH = 2'd2;
    localparam state_t WAIT_LOW  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_toggle_pulse.sv
// Push-button debouncer: qualifies the synchronized input and emits one-cycle press/release pulses.
module debounce_toggle_pulse
    import debounce_defs::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic t_pulse,
    output logic rel_pulse,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             t_nxt;
    logic             rel_nxt;
    logic             busy_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s2)
    );

    // State, counter and output registers; reset discards any pending qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            t_pulse   <= 1'b0;
            rel_pulse <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            btn_level <= level_nxt;
            t_pulse   <= t_nxt;
            rel_pulse <= rel_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next state: a level change is accepted on the STABLE_CYCLES-th consecutive matching sample.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = btn_level;
        t_nxt     = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    level_nxt = 1'b1;
                    t_nxt     = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
    end

endmodule
